// File: rtl/fpu_pkg.sv
// Shared types and helpers for the iterative floating-point divider:
// FSM states, operand classes, exception-flag bundle, exponent bias,
// field positions and canonical special encodings for any EXP_W/MAN_W.
// Optional build macro FPU_DIV_RNE_EN (round-to-nearest-even) is used by the
// divider top, not by this package.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND,
        DONE
    } div_state_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic div_by_zero;
        logic invalid;
    } fp_flags_t;

    // IEEE-style exponent bias: 2^(EXP_W-1) - 1
    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Bit position of the sign field
    function automatic int sign_bit(input int exp_w, input int man_w);
        return exp_w + man_w;
    endfunction

    // Bit position of the exponent field MSB
    function automatic int exp_msb(input int exp_w, input int man_w);
        return exp_w + man_w - 1;
    endfunction

    // Positive infinity: exponent all ones, fraction zero
    function automatic logic [63:0] canon_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        return canon_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_div_classify.sv
// Operand classifier for the divider: classifies the dividend and divisor
// (subnormals fold into ZERO) and resolves every non-(normal/normal) pair
// into its final result and exception flags in a single combinational step.
module fpu_div_classify
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         is_special,
    output logic [W-1:0] special_result,
    output fp_flags_t    special_flags
);

    localparam int SIGN = sign_bit(EXP_W, MAN_W);
    localparam int EMSB = exp_msb(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN    = W'(canon_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0] POS_INF = W'(canon_inf(EXP_W, MAN_W));

    logic [W-1:0] ops [2];
    fp_class_t    cls [2];
    logic         res_sign;

    assign ops[0]   = a;
    assign ops[1]   = b;
    assign res_sign = a[SIGN] ^ b[SIGN];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cls
        logic [EXP_W-1:0] fld_exp;
        logic [MAN_W-1:0] fld_frac;
        assign fld_exp  = ops[gi][EMSB -: EXP_W];
        assign fld_frac = ops[gi][MAN_W-1:0];
        // A zero exponent covers both true zero and subnormals
        assign cls[gi]  = (fld_exp == '0) ? ZERO :
                          (fld_exp == '1) ? ((fld_frac == '0) ? INF : NAN) :
                          NORM;
    end

    // Special-case resolution; only normal/normal falls through to the divider
    always_comb begin
        is_special     = 1'b1;
        special_result = '0;
        special_flags  = '0;
        if (cls[0] == NAN || cls[1] == NAN ||
            (cls[0] == ZERO && cls[1] == ZERO) ||
            (cls[0] == INF  && cls[1] == INF)) begin
            special_result        = QNAN;
            special_flags.invalid = 1'b1;
        end else if (cls[0] == INF) begin
            special_result       = POS_INF;
            special_result[SIGN] = res_sign;
        end else if (cls[1] == ZERO) begin
            special_result            = POS_INF;
            special_result[SIGN]      = res_sign;
            special_flags.div_by_zero = 1'b1;
        end else if (cls[1] == INF || cls[0] == ZERO) begin
            special_result[SIGN] = res_sign;
        end else begin
            is_special = 1'b0;
        end
    end

endmodule

// File: rtl/fpu_iter_divider.sv
// Iterative floating-point divider: radix-2 restoring significand division,
// one quotient bit per cycle, followed by a one-cycle normalise/round stage.
// Special operands bypass the iteration and complete one edge after accept.
// Build macro FPU_DIV_RNE_EN: round-to-nearest-even; otherwise truncate.
module fpu_iter_divider
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         div_by_zero,
    output logic         invalid
);

    localparam int SIGN = sign_bit(EXP_W, MAN_W);
    localparam int EMSB = exp_msb(EXP_W, MAN_W);
    localparam int QW   = MAN_W + 3;   // quotient: integer bit + MAN_W+2 fraction bits
    localparam int RW   = MAN_W + 2;   // partial remainder
    localparam int SW   = MAN_W + 1;   // significand with hidden bit
    localparam int XW   = EXP_W + 2;   // signed exponent working width
    localparam int CW   = $clog2(MAN_W + 3) + 1;

    localparam logic signed [XW-1:0] BIAS     = XW'(exp_bias(EXP_W));
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic [CW-1:0]        LAST_CNT = CW'(MAN_W + 2);

    div_state_t state_reg, state_next;

    logic                 sign_reg;
    logic signed [XW-1:0] exp_reg;
    logic [SW-1:0]        div_reg;
    logic [RW-1:0]        rem_reg;
    logic [QW-1:0]        quo_reg;
    logic [CW-1:0]        cnt_reg;
    logic [W-1:0]         result_reg;
    fp_flags_t            flags_reg;

    logic                 is_special;
    logic [W-1:0]         special_result;
    fp_flags_t            special_flags;

    fpu_div_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_classify (
        .a              (A),
        .b              (B),
        .is_special     (is_special),
        .special_result (special_result),
        .special_flags  (special_flags)
    );

    logic [SW-1:0]        sig_a, sig_b;
    logic signed [XW-1:0] exp_load;

    assign sig_a    = {1'b1, A[MAN_W-1:0]};
    assign sig_b    = {1'b1, B[MAN_W-1:0]};
    assign exp_load = $signed({2'b00, A[EMSB -: EXP_W]})
                    - $signed({2'b00, B[EMSB -: EXP_W]}) + BIAS;

    // One restoring-division step. The accept cycle produces the integer
    // quotient bit straight from the operands, so the whole MAN_W+3-bit
    // quotient is done MAN_W+2 DIV cycles later.
    logic [RW-1:0] step_rem, rem_keep, rem_next;
    logic [SW-1:0] step_div;
    logic [RW:0]   trial;
    logic          q_bit;

    always_comb begin
        step_rem = (state_reg == IDLE) ? {1'b0, sig_a} : rem_reg;
        step_div = (state_reg == IDLE) ? sig_b : div_reg;
        trial    = {1'b0, step_rem} - {2'b00, step_div};
        q_bit    = ~trial[RW];
        rem_keep = q_bit ? trial[RW-1:0] : step_rem;
        rem_next = rem_keep << 1;
    end

    // Normalise, round and range-check the finished quotient
    logic                 q_msb, round_up, carry;
    logic [SW-1:0]        mant_pre;
    logic [SW:0]          mant_rnd;
    logic [MAN_W-1:0]     frac;
    logic signed [XW-1:0] exp_norm, exp_fin;
    logic [W-1:0]         round_result;
    fp_flags_t            round_flags;
`ifdef FPU_DIV_RNE_EN
    logic                 guard, sticky;
`endif

    always_comb begin
        q_msb    = quo_reg[QW-1];
        mant_pre = q_msb ? quo_reg[QW-1:2] : quo_reg[QW-2:1];
        exp_norm = q_msb ? exp_reg : exp_reg - EXP_ONE;
`ifdef FPU_DIV_RNE_EN
        guard    = q_msb ? quo_reg[1] : quo_reg[0];
        sticky   = (q_msb & quo_reg[0]) | (rem_reg != '0);
        round_up = guard & (sticky | mant_pre[0]);
`else
        round_up = 1'b0;
`endif
        mant_rnd = {1'b0, mant_pre} + {{SW{1'b0}}, round_up};
        carry    = mant_rnd[SW];
        exp_fin  = exp_norm + $signed({{(XW-1){1'b0}}, carry});
        frac     = carry ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];

        round_flags  = '0;
        round_result = '0;
        if (exp_fin >= EXP_MAX) begin
            round_result         = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            round_flags.overflow = 1'b1;
        end else if (exp_fin <= EXP_ZERO) begin
            round_result          = {sign_reg, {(W-1){1'b0}}};
            round_flags.underflow = 1'b1;
        end else begin
            round_result = {sign_reg, exp_fin[EXP_W-1:0], frac};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = is_special ? DONE : DIV;
            DIV:     if (cnt_reg == LAST_CNT) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result/flag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_reg   <= 1'b0;
            exp_reg    <= '0;
            div_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg <= A[SIGN] ^ B[SIGN];
                        exp_reg  <= exp_load;
                        div_reg  <= sig_b;
                        rem_reg  <= rem_next;
                        quo_reg  <= {{(QW-1){1'b0}}, q_bit};
                        cnt_reg  <= CW'(1);
                        if (is_special) begin
                            result_reg <= special_result;
                            flags_reg  <= special_flags;
                        end
                    end
                end
                DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[QW-2:0], q_bit};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                ROUND: begin
                    result_reg <= round_result;
                    flags_reg  <= round_flags;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign result      = result_reg;
    assign overflow    = flags_reg.overflow;
    assign underflow   = flags_reg.underflow;
    assign div_by_zero = flags_reg.div_by_zero;
    assign invalid     = flags_reg.invalid;

endmodule

// File: tb/tb_fpu_iter_divider.sv
// Self-checking bench for fpu_iter_divider (single precision defaults).
// Expected results come from hand-derived constants held in a scoreboard
// queue: pushed when an operation is driven, popped when out_valid rises.
module tb_fpu_iter_divider;

    localparam int NORM_LAT = 23 + 4;
    localparam int SPEC_LAT = 1;

`ifdef FPU_DIV_RNE_EN
    localparam logic [31:0] ONE_THIRD   = 32'h3EAAAAAB;
    localparam logic [31:0] FOUR_THIRDS = 32'h3FAAAAAB;
`else
    localparam logic [31:0] ONE_THIRD   = 32'h3EAAAAAA;
    localparam logic [31:0] FOUR_THIRDS = 32'h3FAAAAAA;
`endif

    // flag vector order: {overflow, underflow, div_by_zero, invalid}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_OV   = 4'b1000;
    localparam logic [3:0] F_UF   = 4'b0100;
    localparam logic [3:0] F_DZ   = 4'b0010;
    localparam logic [3:0] F_INV  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, underflow, div_by_zero, invalid;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fpu_iter_divider #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (in_a),
        .B           (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] flag_vec();
        return {overflow, underflow, div_by_zero, invalid};
    endfunction

    // Drive one operation, wait for the result, compare against the scoreboard,
    // then optionally stall out_ready for hold cycles before releasing it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic [3:0] flags,
                          input int lat_exp, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        logic [31:0] held_res;
        logic [3:0]  held_flags;
        e.a = a; e.b = b; e.res = res; e.flags = flags; e.lat = lat_exp;
        sb_q.push_back(e);

        in_a = a; in_b = b; in_valid = 1'b1;
        check_eq("in_ready_before_accept", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        got = sb_q.pop_front();
        check_eq("out_valid_seen", 64'(out_valid), 64'(1));
        check_eq("result", 64'(result), 64'(got.res));
        check_eq("flags", 64'(flag_vec()), 64'(got.flags));
        check_eq("latency", 64'(lat), 64'(got.lat));
        $display("op %h / %h -> %h flags %b latency %0d", got.a, got.b, result, flag_vec(), lat);

        held_res   = got.res;
        held_flags = got.flags;
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin
                in_a = 32'h3F800000; in_b = 32'h00000000; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check_eq("hold_out_valid", 64'(out_valid), 64'(1));
            check_eq("hold_result", 64'(result), 64'(held_res));
            check_eq("hold_flags", 64'(flag_vec()), 64'(held_flags));
            check_eq("hold_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("after_release_out_valid", 64'(out_valid), 64'(0));
        check_eq("after_release_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic saw_valid;

        // Reset behaviour
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out_valid", 64'(out_valid), 64'(0));
        check_eq("reset_result", 64'(result), 64'(0));
        check_eq("reset_flags", 64'(flag_vec()), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("reset_in_ready", 64'(in_ready), 64'(1));

        // Normal path, including a 10-cycle out_ready stall with an ignored in_valid pulse
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, NORM_LAT, 10);
        run_op(32'h3F800000, 32'h40400000, ONE_THIRD,    F_NONE, NORM_LAT, 0);
        run_op(32'h3F800000, 32'h3F400000, FOUR_THIRDS,  F_NONE, NORM_LAT, 0);
        run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, F_NONE, NORM_LAT, 0);
        run_op(32'h3F800000, 32'hBF800000, 32'hBF800000, F_NONE, NORM_LAT, 0);
        run_op(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, F_NONE, NORM_LAT, 0);
        run_op(32'h00800000, 32'h3F800000, 32'h00800000, F_NONE, NORM_LAT, 0);
        // Range limits
        run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, F_OV,   NORM_LAT, 0);
        run_op(32'h00800000, 32'h40000000, 32'h00000000, F_UF,   NORM_LAT, 0);
        // Special operands
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, F_DZ,   SPEC_LAT, 0);
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, F_INV,  SPEC_LAT, 0);
        run_op(32'h7FA00000, 32'h3F800000, 32'h7FC00000, F_INV,  SPEC_LAT, 0);
        run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, F_INV,  SPEC_LAT, 0);
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE, SPEC_LAT, 0);
        run_op(32'h40000000, 32'h7F800000, 32'h00000000, F_NONE, SPEC_LAT, 0);
        run_op(32'h80000000, 32'h40400000, 32'h80000000, F_NONE, SPEC_LAT, 0);
        run_op(32'h00000001, 32'h3F800000, 32'h00000000, F_NONE, SPEC_LAT, 0);
        run_op(32'hBF800000, 32'h00000001, 32'hFF800000, F_DZ,   SPEC_LAT, 0);

        // Reset at DIV cycle 10 abandons the operation
        in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_div_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_div_result", 64'(result), 64'(0));
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check_eq("rst_div_no_output", 64'(saw_valid), 64'(0));
        check_eq("rst_div_in_ready", 64'(in_ready), 64'(1));
        $display("op 40c00000 / 40000000 abandoned by reset in DIV");
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, NORM_LAT, 0);

        // Reset while holding a result in DONE drops it
        in_a = 32'h3F800000; in_b = 32'h00000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("done_before_rst_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_done_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_done_result", 64'(result), 64'(0));
        check_eq("rst_done_flags", 64'(flag_vec()), 64'(0));
        $display("op 3f800000 / 00000000 abandoned by reset in DONE");
        @(posedge clk); #1;
        check_eq("rst_done_in_ready", 64'(in_ready), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_iter_divider.md
FPU_ITER_DIVIDER -- requirements
Module: fpu_iter_divider

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, fraction field width; operand width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports in_valid input 1, in_ready output 1, and A/B inputs of width W, for the dividend and divisor handshake.
REQ-006 The block SHALL have ports out_valid output 1, out_ready input 1, and result output of width W, for the quotient handshake.
REQ-007 The block SHALL have 1-bit outputs overflow, underflow, div_by_zero and invalid, all qualified by out_valid.

Function
REQ-008 The block SHALL have states IDLE, DIV, ROUND and DONE; in_ready = (state==IDLE).
REQ-009 On in_valid&&in_ready, the block SHALL register sign = A.s^B.s, exponent difference plus bias, and both significands with hidden bit, then go to DIV, or to DONE for special operands.
REQ-010 In DIV, the block SHALL perform radix-2 restoring division, one quotient bit per cycle, for exactly MAN_W+3 cycles; sticky = (remainder != 0).
REQ-011 In ROUND, lasting 1 cycle, the block SHALL normalise (quotient MSB 0: shift left 1, exponent -1), round, then enter DONE.
REQ-012 Normal-path latency SHALL be accept edge to out_valid high after MAN_W+4 edges (27 for defaults); special-path latency SHALL be 1 edge.
REQ-013 In DONE, the block SHALL set out_valid=1 and hold result and flags stable until out_ready=1, then return to IDLE on that edge; there is no new accept in the same cycle.
REQ-014 Subnormal inputs SHALL be treated as signed zero.
REQ-015 NaN in either operand, 0/0 or inf/inf SHALL give canonical qNaN (sign 0, exp all-ones, fraction MSB only) and invalid=1.
REQ-016 Finite non-zero/0 SHALL give signed inf and div_by_zero=1; inf/finite SHALL give signed inf; finite/inf or 0/non-zero SHALL give signed zero; all flags 0 unless stated.
REQ-017 A biased result exponent >= all-ones after rounding SHALL give signed inf and overflow=1.
REQ-018 A biased result exponent <= 0 SHALL give signed zero and underflow=1; no subnormal outputs.
REQ-019 A rounding carry out of the significand SHALL increment the exponent, and the overflow check SHALL apply after this increment.

Reset
REQ-020 While rst=1, the block SHALL force state=IDLE, out_valid=0, result=0 and all flags 0; in_ready=1 from the first edge after rst deasserts.
REQ-021 Reset asserted mid-DIV or in DONE SHALL abandon the operation with no output produced.

Configuration
REQ-022 With macro FPU_DIV_RNE_EN defined, ROUND SHALL apply round-to-nearest-even using guard and sticky.
REQ-023 Without FPU_DIV_RNE_EN, ROUND SHALL truncate (round toward zero); latency and ports are unchanged.

Structure
REQ-024 Package fpu_pkg SHALL hold the state enum, bias function of EXP_W, field-slice constants, canonical qNaN/inf constants and the operand-class enum (ZERO, NORM, INF, NAN).
REQ-025 The block SHALL contain one combinational sub-module, fpu_div_classify, that classifies A and B and produces the special-case result and flags.
REQ-026 The divide datapath width SHALL be MAN_W+2 bits for the remainder and MAN_W+3 bits for the quotient.

Verification
REQ-027 A=0x40C00000, B=0x40000000 -> result 0x40400000, out_valid 27 edges after accept, all flags 0.
REQ-028 A=0x3F800000, B=0x40400000 -> result 0x3EAAAAAB with FPU_DIV_RNE_EN, 0x3EAAAAAA without.
REQ-029 A=0x3F800000, B=0x00000000 -> result 0x7F800000, div_by_zero=1, 1-edge latency; A=B=0 -> result 0x7FC00000, invalid=1.
REQ-030 A=0x7F7FFFFF, B=0x3F000000 -> result 0x7F800000, overflow=1; A=0x00800000, B=0x40000000 -> result 0x00000000, underflow=1.
REQ-031 out_ready held low for 10 cycles in DONE -> result/flags stable, in_ready=0; in_valid pulsed during that time is not accepted.
REQ-032 rst pulsed at DIV cycle 10 -> out_valid never rises for that operation; the next operation 6.0/2.0 completes correctly.
